calc_key_ctrl: RTL and testbench
================================

# calc_key_ctrl

Sequencer between the 4x4 keypad scanner and the calculator arithmetic unit. It consumes the scanner's single-cycle key pulses and assembles two BCD operands plus an operator. On '=' it issues one request/acknowledge transaction to the ALU and drives the BCD value shown on the display. It holds all calculator-level entry state; the scanner and the ALU stay stateless with respect to the user's input sequence.

## Interface
- DIGITS, 4, BCD digits per operand; all operand, result and display buses are 4*DIGITS bits wide.
- clk  in  1  system clock; drives the scanner, this block and the ALU.
- rst_n  in  1  asynchronous, active-low reset.
- key_pulse  in  16  one-cycle pulses in the clk domain, bit k = key k. Keys 0-9 are digits 0-9; 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 'C'.
- alu_req  out  1  request; held high until acknowledged.
- alu_op  out  2  operator: 00 add, 01 sub, 10 mul, 11 div.
- alu_a, alu_b  out  4*DIGITS  BCD operands.
- alu_ack  in  1  one-cycle acknowledge; alu_result and alu_err are valid in the same cycle.
- alu_result  in  4*DIGITS  BCD result.
- alu_err  in  1  overflow or divide-by-zero flag.
- disp_bcd  out  4*DIGITS  BCD value for the display driver.
- err  out  1  high in S_ERR.
- busy  out  1  high in S_REQ.

## Operation
- **Key validity:** a cycle counts as a key event only when exactly one key_pulse bit is set. Zero bits or two or more set bits are ignored entirely.
- **States:** S_A, S_OP, S_B, S_REQ, S_RES, S_ERR. Reset state is S_A.
- **'C' (key 15):** from any state, clears A, B, op, digit counts and result, deasserts alu_req and goes to S_A.
- **Digit entry:** operand ← {operand[4*DIGITS-5:0], digit}. A per-operand count increments only on a nonzero digit or when the count is already nonzero, so leading zeros are not counted. When count == DIGITS, further digits are ignored and the operand is unchanged.
- **S_A:**
  - digit → enter into A;
  - operator → latch op, go to S_OP;
  - '=' → ignored.
  - disp = A.
- **S_OP:**
  - digit → B = digit, B count set accordingly, go to S_B;
  - operator → replace op;
  - '=' → ignored.
  - disp = A.
- **S_B:**
  - digit → enter into B;
  - operator → ignored (no precedence, no implicit evaluation);
  - '=' → go to S_REQ.
  - disp = B.
- **S_REQ:**
  - alu_req = 1; alu_a, alu_b and alu_op are stable for the whole request;
  - all keys except 'C' are ignored;
  - on alu_ack: alu_err = 0 → latch result, go to S_RES; alu_err = 1 → go to S_ERR.
  - disp = B.
- **S_RES:**
  - digit → A = digit, B = 0, go to S_A;
  - operator → see Configuration;
  - '=' → ignored.
  - disp = result.
- **S_ERR:** disp = all 4'hF nibbles; err = 1; only 'C' exits.
- **Stray acknowledges:** alu_ack outside S_REQ is ignored, including a late ack after a 'C' abort.
- alu_a and alu_b always reflect the A and B registers. alu_op always reflects the latched op.

## Timing
- **Reset values:**
  - alu_req = 0, alu_op = 00, alu_a = alu_b = 0, disp_bcd = 0, err = 0, busy = 0;
  - A, B, result and counts = 0; state = S_A.
- **Key latency:** a key event at edge n updates registers and state at edge n. disp_bcd, alu_req and busy are registered or state-decoded and are visible after edge n. No combinational path exists from key_pulse to any output.
- **Handshake:**
  - alu_req rises at the edge on which '=' is accepted.
  - alu_ack is sampled at each edge while in S_REQ.
  - alu_req falls and the result is latched at the edge where ack = 1.
  - The minimum request is one cycle when the ALU acks combinationally.
- **Same-cycle 'C' and alu_ack in S_REQ:** 'C' wins and the result is discarded.
- **Reset mid-request:** alu_req drops immediately and asynchronously.

## Configuration
- **CALC_KEY_CTRL_CHAIN_EN defined:** an operator in S_RES loads A ← result, sets A's count to the number of significant digits in result, latches op and goes to S_OP. This chains calculations.
- **Not defined:** an operator in S_RES is ignored. Only a digit or 'C' leaves S_RES.

## Test plan
- **Basic add:** reset, keys 1, 2, '+', 3, '=', ALU acks after 2 cycles with 0x0015. Expect alu_a = 0x0012, alu_b = 0x0003, alu_op = 00 and alu_req high for exactly 3 cycles; then disp_bcd = 0x0015 and busy = 0.
- **Digit limit and leading zeros:** keys 0, 0, 1, 2, 3, 4, 5. Expect A = 0x1234; the 5 is ignored.
- **Invalid pulse:** key_pulse = 0x0003 (keys 0 and 1 together). Expect no change to state, registers or disp_bcd.
- **Divide error:** keys 7, '/', 0, '=', ALU returns alu_err = 1. Expect err = 1 and disp_bcd = 0xFFFF. Digit keys are then ignored; 'C' returns to S_A with disp_bcd = 0 and err = 0.
- **Abort mid-request:** 'C' in the same cycle as alu_ack. Expect alu_req = 0, state S_A, result discarded. A late ack one cycle later causes no change.
- **Chaining:**
  - With CALC_KEY_CTRL_CHAIN_EN: result 0x0015, then '-', 5, '='. Expect alu_a = 0x0015, alu_op = 01, alu_b = 0x0005.
  - Without it: the '-' is ignored and disp_bcd stays 0x0015.

Source files
------------

// File: rtl/calc_key_ctrl.sv
// Keypad-to-ALU sequencer: assembles two BCD operands and an operator, runs one ALU handshake per '='.
// Optional macro CALC_KEY_CTRL_CHAIN_EN: an operator pressed on a result starts a new calculation from it.
module calc_key_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           key_pulse,
  output logic                  alu_req,
  output logic [1:0]            alu_op,
  output logic [4*DIGITS-1:0]   alu_a,
  output logic [4*DIGITS-1:0]   alu_b,
  input  logic                  alu_ack,
  input  logic [4*DIGITS-1:0]   alu_result,
  input  logic                  alu_err,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic                  err,
  output logic                  busy
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {S_A, S_OP, S_B, S_REQ, S_RES, S_ERR} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [1:0]      op_q, op_d;

  logic            key_vld, is_dig, is_op, is_eq, is_clr;
  logic [3:0]      key_idx;

`ifdef CALC_KEY_CTRL_CHAIN_EN
  function automatic logic [CW-1:0] sig_cnt(input logic [W-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] != 4'd0) c = CW'(i + 1);
    return c;
  endfunction
`endif

  // Exactly one bit set qualifies as a key; anything else is dropped.
  always_comb begin
    key_vld = (key_pulse != 16'd0) && ((key_pulse & (key_pulse - 16'd1)) == 16'd0);
    key_idx = 4'd0;
    for (int k = 0; k < 16; k++)
      if (key_pulse[k]) key_idx = 4'(k);
    is_dig = key_vld && (key_idx <= 4'd9);
    is_op  = key_vld && (key_idx >= 4'd10) && (key_idx <= 4'd13);
    is_eq  = key_vld && (key_idx == 4'd14);
    is_clr = key_vld && (key_idx == 4'd15);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    op_d    = op_q;
    case (state_q)
      S_A: begin
        if (is_dig) begin
          if (cnt_a_q != CW'(DIGITS)) begin
            a_d = {a_q[W-5:0], key_idx};
            if (key_idx != 4'd0 || cnt_a_q != '0) cnt_a_d = cnt_a_q + CW'(1);
          end
        end else if (is_op) begin
          op_d    = 2'(key_idx - 4'd10);
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (is_dig) begin
          b_d     = W'(key_idx);
          cnt_b_d = (key_idx != 4'd0) ? CW'(1) : '0;
          state_d = S_B;
        end else if (is_op) begin
          op_d = 2'(key_idx - 4'd10);
        end
      end
      S_B: begin
        if (is_dig) begin
          if (cnt_b_q != CW'(DIGITS)) begin
            b_d = {b_q[W-5:0], key_idx};
            if (key_idx != 4'd0 || cnt_b_q != '0) cnt_b_d = cnt_b_q + CW'(1);
          end
        end else if (is_eq) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (alu_ack) begin
          if (alu_err) state_d = S_ERR;
          else begin
            res_d   = alu_result;
            state_d = S_RES;
          end
        end
      end
      S_RES: begin
        if (is_dig) begin
          a_d     = W'(key_idx);
          cnt_a_d = (key_idx != 4'd0) ? CW'(1) : '0;
          b_d     = '0;
          cnt_b_d = '0;
          state_d = S_A;
        end
`ifdef CALC_KEY_CTRL_CHAIN_EN
        else if (is_op) begin
          a_d     = res_q;
          cnt_a_d = sig_cnt(res_q);
          op_d    = 2'(key_idx - 4'd10);
          state_d = S_OP;
        end
`endif
      end
      default: ;
    endcase
    // Clear overrides everything, including an ack arriving in the same cycle.
    if (is_clr) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      op_d    = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    disp_bcd = a_q;
    case (state_q)
      S_B, S_REQ: disp_bcd = b_q;
      S_RES:      disp_bcd = res_q;
      S_ERR:      disp_bcd = {DIGITS{4'hF}};
      default:    disp_bcd = a_q;
    endcase
  end

  assign alu_req = (state_q == S_REQ);
  assign busy    = (state_q == S_REQ);
  assign err     = (state_q == S_ERR);
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_op  = op_q;
endmodule

// File: tb/tb_calc_key_ctrl.sv
// Directed bench for calc_key_ctrl: inputs change on the falling edge, outputs are checked there too.
module tb_calc_key_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] key_pulse;
  logic        alu_req;
  logic [1:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result, disp_bcd;
  logic        alu_ack, alu_err, err, busy;

  int n_cmp = 0;
  int n_err = 0;

  calc_key_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse),
    .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ack(alu_ack), .alu_result(alu_result), .alu_err(alu_err),
    .disp_bcd(disp_bcd), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle pulse; returns on the falling edge after the capturing edge.
  task automatic press(input int k);
    @(negedge clk);
    key_pulse = 16'(1) << k;
    @(negedge clk);
    key_pulse = 16'h0000;
  endtask

  initial begin
    rst_n = 1'b0; key_pulse = '0; alu_ack = 1'b0; alu_err = 1'b0; alu_result = '0;
    #12;
    chk("rst_req",  alu_req,  0);
    chk("rst_op",   alu_op,   0);
    chk("rst_a",    alu_a,    0);
    chk("rst_b",    alu_b,    0);
    chk("rst_disp", disp_bcd, 0);
    chk("rst_err",  err,      0);
    chk("rst_busy", busy,     0);
    @(negedge clk); rst_n = 1'b1;

    // 12 + 3 = 15, ALU acks in the third request cycle
    press(1); press(2);
    chk("add_dispA", disp_bcd, 16'h0012);
    press(10);
    chk("add_dispOp", disp_bcd, 16'h0012);
    press(3);
    chk("add_dispB", disp_bcd, 16'h0003);
    press(14);
    chk("add_req1", alu_req, 1);
    chk("add_busy", busy, 1);
    chk("add_a",  alu_a,  16'h0012);
    chk("add_b",  alu_b,  16'h0003);
    chk("add_op", alu_op, 2'b00);
    @(negedge clk);
    chk("add_req2", alu_req, 1);
    @(negedge clk);
    chk("add_req3", alu_req, 1);
    alu_ack = 1'b1; alu_result = 16'h0015;
    @(negedge clk);
    alu_ack = 1'b0; alu_result = 16'h0000;
    chk("add_req_fall", alu_req, 0);
    chk("add_res", disp_bcd, 16'h0015);
    chk("add_busy0", busy, 0);

    // operator on a result
    press(11);
`ifdef CALC_KEY_CTRL_CHAIN_EN
    chk("chain_disp", disp_bcd, 16'h0015);
    press(5); press(14);
    chk("chain_a",  alu_a,  16'h0015);
    chk("chain_op", alu_op, 2'b01);
    chk("chain_b",  alu_b,  16'h0005);
    alu_ack = 1'b1; alu_result = 16'h0010;
    @(negedge clk);
    alu_ack = 1'b0;
    chk("chain_res", disp_bcd, 16'h0010);
`else
    chk("nochain_disp", disp_bcd, 16'h0015);
    chk("nochain_op", alu_op, 2'b00);
    press(5);
    chk("res_digit_a", disp_bcd, 16'h0005);
    chk("res_digit_b", alu_b, 16'h0000);
`endif

    // digit limit and leading zeros
    press(15);
    chk("clr_disp", disp_bcd, 16'h0000);
    chk("clr_op", alu_op, 2'b00);
    press(0); press(0);
    chk("lz_disp", disp_bcd, 16'h0000);
    press(1); press(2); press(3); press(4);
    chk("lim_disp4", disp_bcd, 16'h1234);
    press(5);
    chk("lim_disp5", alu_a, 16'h1234);

    // multi-bit pulses are ignored
    @(negedge clk); key_pulse = 16'h0003;
    @(negedge clk); key_pulse = 16'h0000;
    chk("inv_disp", disp_bcd, 16'h1234);
    @(negedge clk); key_pulse = 16'h4400;
    @(negedge clk); key_pulse = 16'h0000;
    chk("inv_op_busy", busy, 0);
    chk("inv_op", alu_op, 2'b00);
    press(10);
    chk("op_add", alu_op, 2'b00);
    press(12);
    chk("op_replace", alu_op, 2'b10);
    press(14);
    chk("op_eq_ign", busy, 0);

    // divide by zero
    press(15); press(7); press(13); press(0); press(14);
    chk("div_req", alu_req, 1);
    chk("div_op", alu_op, 2'b11);
    alu_ack = 1'b1; alu_err = 1'b1;
    @(negedge clk);
    alu_ack = 1'b0; alu_err = 1'b0;
    chk("div_err", err, 1);
    chk("div_disp", disp_bcd, 16'hFFFF);
    chk("div_req0", alu_req, 0);
    press(3);
    chk("err_digit", disp_bcd, 16'hFFFF);
    press(15);
    chk("err_clr_disp", disp_bcd, 16'h0000);
    chk("err_clr_err", err, 0);

    // 'C' together with ack aborts; late ack afterwards is ignored
    press(9); press(10); press(1); press(14);
    chk("abort_req1", alu_req, 1);
    key_pulse = 16'h8000; alu_ack = 1'b1; alu_result = 16'h0010;
    @(negedge clk);
    key_pulse = 16'h0000; alu_ack = 1'b0;
    chk("abort_req0", alu_req, 0);
    chk("abort_disp", disp_bcd, 16'h0000);
    chk("abort_a", alu_a, 16'h0000);
    alu_ack = 1'b1; alu_result = 16'h0099;
    @(negedge clk);
    alu_ack = 1'b0;
    chk("late_disp", disp_bcd, 16'h0000);
    chk("late_busy", busy, 0);
    press(4);
    chk("late_sA", disp_bcd, 16'h0004);
    press(14);
    chk("eq_in_A", busy, 0);

    // reset drops the request without waiting for a clock edge
    press(10); press(2); press(14);
    chk("mid_req1", alu_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_req0", alu_req, 0);
    chk("mid_a0", alu_a, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_disp", disp_bcd, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
